mips_sopc: RTL and testbench

//  Top-level system-on-programmable-chip for the 5-stage MIPS32 pipeline.

---
 rtl/mips_sopc_pkg.sv | 88 ++++++++
 rtl/mips_sopc_if.sv | 18 +
 rtl/mips_sopc_cpu.sv | 272 +++++++++++++++++++++++++++
 rtl/mips_sopc_rom.sv | 34 +++
 rtl/mips_sopc.sv | 31 +++
 tb/tb_mips_sopc.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/mips_sopc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sopc_pkg
//  Description : Shared MIPS32 constants for the SoPC: opcodes, funct codes,
//                internal ALU operation encoding and pipeline latch layouts.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_sopc_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam int          REG_COUNT  = 32;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // ALU_NOP must stay the all-zero encoding so a cleared latch is a bubble.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13,
    ALU_MTHI = 4'd14,
    ALU_MTLO = 4'd15
  } alu_op_e;

  // ID/EX latch: operation plus fully resolved operands. Shifts take their
  // amount from a[4:0] and shift b.
  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wreg;
    logic [4:0]  waddr;
  } ex_ctl_t;

  // EX/MEM and MEM/WB latches: a result headed for a GPR, hi or lo.
  typedef struct packed {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whi;
    logic        wlo;
  } wb_ctl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_sopc_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sopc_if
//  Description : Instruction-fetch bus between the core (master) and the
//                instruction ROM (slave). Byte address, enable, read word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_sopc_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           address;
  logic                  enable;
  logic [DATA_WIDTH-1:0] data;

  modport master (output address, output enable, input data);
  modport slave  (input address, input enable, output data);
endinterface
`default_nettype wire

// File: rtl/mips_sopc_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sopc_cpu (+ mips_sopc_regfile, mips_sopc_stage_wb)
//  Description : Five-stage MIPS32 integer pipeline (IF/ID/EX/MEM/WB) for
//                ALU-class instructions including hi/lo moves. Operands are
//                forwarded from EX and MEM into ID, and the register file is
//                write-first, so dependent ALU code runs without bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================

// 32 x 32 general-purpose register file, $0 hard-wired to zero.
module mips_sopc_regfile
  import mips_sopc_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        we_i,
  input  wire logic [4:0]  waddr_i,
  input  wire logic [31:0] wdata_i,
  input  wire logic [4:0]  raddr1_i,
  output logic      [31:0] rdata1_o,
  input  wire logic [4:0]  raddr2_i,
  output logic      [31:0] rdata2_o
);

  logic [31:0] storage [0:REG_COUNT-1];

  // Register write; $0 is never written so it reads zero forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) storage[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      storage[waddr_i] <= wdata_i;
    end
  end

  // Read ports bypass a same-cycle write so ID sees the value being retired.
  always_comb begin
    if (raddr1_i == 5'd0)                      rdata1_o = '0;
    else if (we_i && (waddr_i == raddr1_i))    rdata1_o = wdata_i;
    else                                       rdata1_o = storage[raddr1_i];
    if (raddr2_i == 5'd0)                      rdata2_o = '0;
    else if (we_i && (waddr_i == raddr2_i))    rdata2_o = wdata_i;
    else                                       rdata2_o = storage[raddr2_i];
  end

endmodule

// Write-back stage state: the hi/lo special registers.
module mips_sopc_stage_wb (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        whi_i,
  input  wire logic        wlo_i,
  input  wire logic [31:0] wdata_i,
  output logic      [31:0] register_hi_read_data,
  output logic      [31:0] register_lo_read_data
);

  logic [31:0] hi_q, lo_q;

  // hi/lo update at retirement of mthi/mtlo.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (whi_i) hi_q <= wdata_i;
      if (wlo_i) lo_q <= wdata_i;
    end
  end

  assign register_hi_read_data = hi_q;
  assign register_lo_read_data = lo_q;

endmodule

module mips_sopc_cpu
  import mips_sopc_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,
  mips_sopc_if.master rom_bus
);

  // Fetch state and pipeline latches
  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  ex_ctl_t     ex_q, ex_d;
  wb_ctl_t     mem_q, mem_d;
  wb_ctl_t     wb_q, wb_d;

  // Decode fields and helpers
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic        re1, re2, use_imm, use_sa, wreg;
  logic [31:0] imm_val;
  logic [31:0] rf_rdata1, rf_rdata2;

  // Execute results
  wb_ctl_t     ex_res;
  logic [31:0] hi_rd, lo_rd, hi_fwd, lo_fwd;

  assign rom_bus.address = pc_q;
  assign rom_bus.enable  = ce_q;

  // Fetch: pc holds at zero on the first enabled edge, then steps by a word.
  always_comb begin
    ce_d      = 1'b1;
    pc_d      = ce_q ? (pc_q + 32'd4) : 32'h0;
    id_inst_d = rom_bus.data;
  end

  // Decode and operand selection with EX/MEM forwarding into ID.
  always_comb begin
    opcode  = id_inst_q[31:26];
    rs      = id_inst_q[25:21];
    rt      = id_inst_q[20:16];
    rd      = id_inst_q[15:11];
    sa      = id_inst_q[10:6];
    funct   = id_inst_q[5:0];
    imm     = id_inst_q[15:0];
    re1     = 1'b0;
    re2     = 1'b0;
    use_imm = 1'b0;
    use_sa  = 1'b0;
    wreg    = 1'b0;
    imm_val = '0;
    ex_d    = '0;
    ex_d.waddr = rd;

    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL:  begin ex_d.op = ALU_SLL;  re2 = 1'b1; use_sa = 1'b1; wreg = 1'b1; end
          FN_SRL:  begin ex_d.op = ALU_SRL;  re2 = 1'b1; use_sa = 1'b1; wreg = 1'b1; end
          FN_SRA:  begin ex_d.op = ALU_SRA;  re2 = 1'b1; use_sa = 1'b1; wreg = 1'b1; end
          FN_SLLV: begin ex_d.op = ALU_SLL;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_SRLV: begin ex_d.op = ALU_SRL;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_SRAV: begin ex_d.op = ALU_SRA;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_MFHI: begin ex_d.op = ALU_MFHI; wreg = 1'b1; end
          FN_MFLO: begin ex_d.op = ALU_MFLO; wreg = 1'b1; end
          FN_MTHI: begin ex_d.op = ALU_MTHI; re1 = 1'b1; end
          FN_MTLO: begin ex_d.op = ALU_MTLO; re1 = 1'b1; end
          FN_ADDU: begin ex_d.op = ALU_ADD;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_SUBU: begin ex_d.op = ALU_SUB;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_AND:  begin ex_d.op = ALU_AND;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_OR:   begin ex_d.op = ALU_OR;   re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_XOR:  begin ex_d.op = ALU_XOR;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_NOR:  begin ex_d.op = ALU_NOR;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_SLT:  begin ex_d.op = ALU_SLT;  re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          FN_SLTU: begin ex_d.op = ALU_SLTU; re1 = 1'b1; re2 = 1'b1; wreg = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDIU: begin ex_d.op = ALU_ADD;  re1 = 1'b1; imm_val = sign_ext16(imm); end
      OP_SLTI:  begin ex_d.op = ALU_SLT;  re1 = 1'b1; imm_val = sign_ext16(imm); end
      OP_SLTIU: begin ex_d.op = ALU_SLTU; re1 = 1'b1; imm_val = sign_ext16(imm); end
      OP_ANDI:  begin ex_d.op = ALU_AND;  re1 = 1'b1; imm_val = {16'h0, imm}; end
      OP_ORI:   begin ex_d.op = ALU_OR;   re1 = 1'b1; imm_val = {16'h0, imm}; end
      OP_XORI:  begin ex_d.op = ALU_XOR;  re1 = 1'b1; imm_val = {16'h0, imm}; end
      OP_LUI:   begin ex_d.op = ALU_OR;   imm_val = {imm, 16'h0}; end
      default: ;
    endcase

    // Every I-type that reaches here writes rt.
    if ((opcode != OP_SPECIAL) && (ex_d.op != ALU_NOP)) begin
      use_imm    = 1'b1;
      wreg       = 1'b1;
      ex_d.waddr = rt;
    end

    // $0 destinations are dropped here so they can never be forwarded.
    ex_d.wreg = wreg && (ex_d.waddr != 5'd0);

    // Operand A: youngest producer wins (EX, then MEM, then regfile/WB).
    if (re1) begin
      if (ex_q.wreg && (ex_q.waddr == rs))        ex_d.a = ex_res.wdata;
      else if (mem_q.wreg && (mem_q.waddr == rs)) ex_d.a = mem_q.wdata;
      else                                        ex_d.a = rf_rdata1;
    end else if (use_sa) begin
      ex_d.a = {27'b0, sa};
    end

    // Operand B: immediate or forwarded rt.
    if (use_imm) begin
      ex_d.b = imm_val;
    end else if (re2) begin
      if (ex_q.wreg && (ex_q.waddr == rt))        ex_d.b = ex_res.wdata;
      else if (mem_q.wreg && (mem_q.waddr == rt)) ex_d.b = mem_q.wdata;
      else                                        ex_d.b = rf_rdata2;
    end
  end

  // Execute: ALU plus hi/lo reads forwarded from in-flight mthi/mtlo.
  always_comb begin
    hi_fwd = mem_q.whi ? mem_q.wdata : (wb_q.whi ? wb_q.wdata : hi_rd);
    lo_fwd = mem_q.wlo ? mem_q.wdata : (wb_q.wlo ? wb_q.wdata : lo_rd);
    ex_res       = '0;
    ex_res.wreg  = ex_q.wreg;
    ex_res.waddr = ex_q.waddr;
    case (ex_q.op)
      ALU_ADD:  ex_res.wdata = ex_q.a + ex_q.b;
      ALU_SUB:  ex_res.wdata = ex_q.a - ex_q.b;
      ALU_AND:  ex_res.wdata = ex_q.a & ex_q.b;
      ALU_OR:   ex_res.wdata = ex_q.a | ex_q.b;
      ALU_XOR:  ex_res.wdata = ex_q.a ^ ex_q.b;
      ALU_NOR:  ex_res.wdata = ~(ex_q.a | ex_q.b);
      ALU_SLT:  ex_res.wdata = {31'b0, ($signed(ex_q.a) < $signed(ex_q.b))};
      ALU_SLTU: ex_res.wdata = {31'b0, (ex_q.a < ex_q.b)};
      ALU_SLL:  ex_res.wdata = ex_q.b << ex_q.a[4:0];
      ALU_SRL:  ex_res.wdata = ex_q.b >> ex_q.a[4:0];
      ALU_SRA:  ex_res.wdata = 32'($signed(ex_q.b) >>> ex_q.a[4:0]);
      ALU_MFHI: ex_res.wdata = hi_fwd;
      ALU_MFLO: ex_res.wdata = lo_fwd;
      ALU_MTHI: begin ex_res.wdata = ex_q.a; ex_res.whi = 1'b1; end
      ALU_MTLO: begin ex_res.wdata = ex_q.a; ex_res.wlo = 1'b1; end
      default:  ex_res.wdata = '0;
    endcase
  end

  // MEM is a pass-through for ALU-only code.
  always_comb begin
    mem_d = ex_res;
    wb_d  = mem_q;
  end

  // Pipeline register update; reset flushes every latch to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q      <= 1'b0;
      pc_q      <= 32'h0;
      id_inst_q <= NOP_WORD;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
    end else begin
      ce_q      <= ce_d;
      pc_q      <= pc_d;
      id_inst_q <= id_inst_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
    end
  end

  mips_sopc_regfile register (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_q.wreg),
    .waddr_i  (wb_q.waddr),
    .wdata_i  (wb_q.wdata),
    .raddr1_i (rs),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rt),
    .rdata2_o (rf_rdata2)
  );

  mips_sopc_stage_wb stage_wb (
    .clk                   (clk),
    .rst                   (rst),
    .whi_i                 (wb_q.whi),
    .wlo_i                 (wb_q.wlo),
    .wdata_i               (wb_q.wdata),
    .register_hi_read_data (hi_rd),
    .register_lo_read_data (lo_rd)
  );

endmodule
`default_nettype wire

// File: rtl/mips_sopc_rom.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sopc_rom
//  Description : Word-organised instruction ROM with a combinational read.
//                Returns the nop word when disabled or addressed out of range.
//                The image is placed into storage by the simulation environment.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_sopc_rom
  import mips_sopc_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 10
) (
  mips_sopc_if.slave bus
);

  logic [31:0] storage [0:(2**ROM_ADDR_WIDTH)-1];
  logic        in_range;
  logic [1:0]  unused_byte_offset;

  // Byte offset within a word has no meaning for instruction fetch.
  assign unused_byte_offset = bus.address[1:0];

  // Word lookup; anything above the ROM depth reads as a nop.
  always_comb begin
    in_range = (bus.address[31:ROM_ADDR_WIDTH+2] == '0);
    bus.data = NOP_WORD;
    if (bus.enable && in_range) begin
      bus.data = storage[bus.address[ROM_ADDR_WIDTH+1:2]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_sopc.sv
`default_nettype none
// ============================================================================
//  Module      : mips_sopc
//  Description : MIPS32 system-on-programmable-chip: pipelined core plus
//                instruction ROM joined by the fetch bus. Wiring only.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_sopc
  import mips_sopc_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
) (
  input wire logic clock,
  input wire logic reset
);

  mips_sopc_if #(.DATA_WIDTH(DATA_WIDTH)) rom_bus ();

  mips_sopc_cpu cpu (
    .clk     (clock),
    .rst     (reset),
    .rom_bus (rom_bus.master)
  );

  mips_sopc_rom #(.ROM_ADDR_WIDTH(ROM_ADDR_WIDTH)) rom (
    .bus (rom_bus.slave)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_sopc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_sopc
//  Description : Self-checking bench for mips_sopc. Programs are placed into
//                the ROM, run from reset, and the architectural state is
//                compared each cycle against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_sopc;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] prog [$];
  logic [31:0] m_reg [32];
  logic [31:0] m_hi, m_lo;

  logic [5:0] iops [7]  = '{6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
  logic [5:0] rfns [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24,
                            6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h10, 6'h11, 6'h12, 6'h13};

  mips_sopc #(.ROM_ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one instruction, straight from the ISA definition.
  task automatic model_exec(input logic [31:0] w);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] a, b, se, ze, r;
    int          dst;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6]; fn = w[5:0];
    a  = m_reg[rs]; b = m_reg[rt];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    r  = 32'h0;
    dst = -1;
    if (op == 6'h00) begin
      dst = rd;
      case (fn)
        6'h00: r = b << sa;
        6'h02: r = b >> sa;
        6'h03: r = $signed(b) >>> sa;
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = $signed(b) >>> a[4:0];
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h11: begin m_hi = a; dst = -1; end
        6'h13: begin m_lo = a; dst = -1; end
        6'h21: r = a + b;
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2b: r = (a < b) ? 32'd1 : 32'd0;
        default: dst = -1;
      endcase
    end else begin
      dst = rt;
      case (op)
        6'h09: r = a + se;
        6'h0a: r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0b: r = (a < se) ? 32'd1 : 32'd0;
        6'h0c: r = a & ze;
        6'h0d: r = a | ze;
        6'h0e: r = a ^ ze;
        6'h0f: r = {w[15:0], 16'h0};
        default: dst = -1;
      endcase
    end
    if (dst > 0) m_reg[dst] = r;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s r%0d", tag, i), dut.cpu.register.storage[i], m_reg[i]);
    end
    check({tag, " hi"}, dut.cpu.stage_wb.register_hi_read_data, m_hi);
    check({tag, " lo"}, dut.cpu.stage_wb.register_lo_read_data, m_lo);
  endtask

  // Hold reset for 'hold' edges with prog in ROM, release, and follow for
  // 'edges' edges after the release edge. The instruction at word k retires
  // on edge k+5 counted from the release edge.
  task automatic run_program(input int hold, input int edges);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.rom.storage[i] = (i < prog.size()) ? prog[i] : 32'h0;
    repeat (hold) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    check("pc in reset", dut.cpu.pc_q, 32'h0);
    check("enable in reset", {31'b0, dut.rom_bus.enable}, 32'h0);
    check("rom data disabled", dut.rom_bus.data, 32'h0);
    check_state("after reset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("pc on release edge", dut.cpu.pc_q, 32'h0);
    check("enable on release edge", {31'b0, dut.rom_bus.enable}, 32'h1);
    for (int n = 1; n <= edges; n++) begin
      @(posedge clock);
      #1;
      if (n >= 5) model_exec((n - 5 < prog.size()) ? prog[n - 5] : 32'h0);
      check($sformatf("pc e%0d", n), dut.cpu.pc_q, 32'(4 * n));
      check_state($sformatf("e%0d", n));
    end
  endtask

  task automatic gen_random(input int len);
    logic [4:0]  s, t, d, sa;
    logic [15:0] imm;
    prog.delete();
    for (int k = 0; k < len; k++) begin
      s   = 5'($urandom_range(0, 7));
      t   = 5'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 7));
      sa  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      if ($urandom_range(0, 9) < 4) prog.push_back(enc_i(iops[$urandom_range(0, 6)], s, t, imm));
      else                          prog.push_back(enc_r(s, t, d, sa, rfns[$urandom_range(0, 17)]));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.rom.storage[i] = 32'h0;

    // Four independent ori loads, 10-cycle reset.
    prog = '{enc_i(6'h0d, 0, 1, 16'h1100), enc_i(6'h0d, 0, 2, 16'h0020),
             enc_i(6'h0d, 0, 3, 16'hff00), enc_i(6'h0d, 0, 4, 16'hffff)};
    run_program(10, 12);
    check("ori r1", dut.cpu.register.storage[1], 32'h0000_1100);
    check("ori r2", dut.cpu.register.storage[2], 32'h0000_0020);
    check("ori r3", dut.cpu.register.storage[3], 32'h0000_ff00);
    check("ori r4", dut.cpu.register.storage[4], 32'h0000_ffff);

    // Back-to-back dependent chain through forwarding.
    prog = '{enc_i(6'h0d, 0, 1, 16'h1100), enc_i(6'h0d, 1, 1, 16'h0020),
             enc_i(6'h0d, 1, 1, 16'h4400)};
    run_program(2, 10);
    check("fwd r1", dut.cpu.register.storage[1], 32'h0000_5520);

    // hi/lo moves.
    prog = '{enc_i(6'h0f, 0, 1, 16'h1234), enc_r(1, 0, 0, 0, 6'h11), enc_r(0, 0, 0, 0, 6'h13)};
    run_program(2, 10);
    check("hi value", dut.cpu.stage_wb.register_hi_read_data, 32'h1234_0000);
    check("lo value", dut.cpu.stage_wb.register_lo_read_data, 32'h0000_0000);

    // Write to $0, then run well past the image end.
    prog = '{enc_i(6'h0d, 0, 0, 16'hffff), enc_i(6'h0d, 0, 5, 16'h0001), enc_r(0, 0, 0, 0, 6'h00)};
    run_program(2, 16);
    check("r0 stays zero", dut.cpu.register.storage[0], 32'h0);

    // Reset for one cycle mid-program, then re-run to completion.
    gen_random(12);
    run_program(3, 9);
    run_program(1, 20);

    // Random ALU programs with dense register reuse.
    for (int p = 0; p < 4; p++) begin
      gen_random(30);
      run_program(2, 38);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
